fetch_redirect_controller: RTL and testbench

Sequencer for the fetch/decode front end. Each cycle it chooses the next fetch PC from four sources: the sequential/JAL prediction, a JALR target resolved later in the pipe, a mispredict correction, or a hold. It also issues fetch stalls, hiccup bubbles and front-end flushes for load-use hazards, JALR/RET waits and mispredicts. It sits between the predictor/execute feedback paths and the fetch PC register, and keeps saturating stall/flush counters for performance work.

---
 rtl/fetch_redirect_controller_pkg.sv | 29 ++
 rtl/fetch_redirect_controller_if.sv | 41 ++++
 rtl/fetch_redirect_controller_sat_counter.sv | 30 +++
 rtl/fetch_redirect_controller.sv | 108 ++++++++++
 tb/tb_fetch_redirect_controller.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_redirect_controller_pkg.sv
`default_nettype none
// ============================================================
// Package : fetch_redirect_controller_pkg
// Front-end writeback/fetch-target codes and redirect FSM states.
// Rev     : 1.0
// ============================================================
package fetch_redirect_controller_pkg;

  localparam logic [1:0] WB_NORMAL  = 2'd0;
  localparam logic [1:0] WB_HICCUP  = 2'd1;

  localparam logic [1:0] FT_SEQ     = 2'd0;
  localparam logic [1:0] FT_JALR    = 2'd1;
  localparam logic [1:0] FT_CORRECT = 2'd2;
  localparam logic [1:0] FT_HOLD    = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LOAD_HOLD = 2'd1,
    ST_JALR_WAIT = 2'd2,
    ST_FLUSH     = 2'd3
  } fr_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_redirect_controller_if.sv
`default_nettype none
// ============================================================
// Interface : fetch_redirect_if
// Predictor/decode/execute feedback into the redirect controller.
// Rev       : 1.0
// ============================================================
interface fetch_redirect_if #(
  parameter int PERF_WIDTH = 32
);
  logic [31:0]           predict_pc;
  logic [4:0]            fetch_rs1;
  logic [4:0]            fetch_rs2;
  logic                  fetch_is_jalr;
  logic                  dec_valid;
  logic                  dec_is_load;
  logic [4:0]            dec_rd;
  logic                  jalr_resolve;
  logic [31:0]           jalr_target;
  logic                  mispredict;
  logic [31:0]           correct_pc;
  logic [31:0]           pc;
  logic                  fetch_stall;
  logic                  insert_bubble;
  logic                  flush_front;
  logic [1:0]            state;
  logic [PERF_WIDTH-1:0] stall_count;
  logic [PERF_WIDTH-1:0] flush_count;

  modport slave (
    input  predict_pc, fetch_rs1, fetch_rs2, fetch_is_jalr, dec_valid, dec_is_load,
           dec_rd, jalr_resolve, jalr_target, mispredict, correct_pc,
    output pc, fetch_stall, insert_bubble, flush_front, state, stall_count, flush_count
  );

  modport master (
    output predict_pc, fetch_rs1, fetch_rs2, fetch_is_jalr, dec_valid, dec_is_load,
           dec_rd, jalr_resolve, jalr_target, mispredict, correct_pc,
    input  pc, fetch_stall, insert_bubble, flush_front, state, stall_count, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_redirect_controller_sat_counter.sv
`default_nettype none
// ============================================================
// Module : sat_counter
// Up-counter that sticks at all-ones; synchronous clear.
// Rev    : 1.0
// ============================================================
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_redirect_controller.sv
`default_nettype none
// ============================================================
// Module : fetch_redirect_controller
// Next-fetch-PC select with load-use, JALR-wait and mispredict sequencing.
// Rev    : 1.0
// ============================================================
module fetch_redirect_controller
  import fetch_redirect_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          PERF_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  fetch_redirect_if.slave  bus
);

  fr_state_e   r_state;
  fr_state_e   w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [1:0]  w_pc_sel;
  logic        w_load_use;

  assign w_load_use = bus.dec_valid && bus.dec_is_load && (bus.dec_rd != 5'd0) &&
                      ((bus.dec_rd == bus.fetch_rs1) || (bus.dec_rd == bus.fetch_rs2));

  // Hazards are only examined in RUN, so LOAD_HOLD can never re-stall itself.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_sel    = FT_HOLD;
    if (bus.mispredict) begin
      w_pc_sel    = FT_CORRECT;
      w_state_nxt = ST_FLUSH;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_load_use) begin
            w_state_nxt = ST_LOAD_HOLD;
          end else if (bus.fetch_is_jalr) begin
            w_state_nxt = ST_JALR_WAIT;
          end else begin
            w_pc_sel = FT_SEQ;
          end
        end
        ST_LOAD_HOLD: begin
          w_state_nxt = ST_RUN;
        end
        ST_JALR_WAIT: begin
          if (bus.jalr_resolve) begin
            w_pc_sel    = FT_JALR;
            w_state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          w_pc_sel    = FT_SEQ;
          w_state_nxt = ST_RUN;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    case (w_pc_sel)
      FT_SEQ:     w_pc_nxt = align_pc(bus.predict_pc);
      FT_JALR:    w_pc_nxt = align_pc(bus.jalr_target);
      FT_CORRECT: w_pc_nxt = align_pc(bus.correct_pc);
      default:    w_pc_nxt = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  assign bus.pc            = r_pc;
  assign bus.state         = r_state;
  assign bus.fetch_stall   = (r_state == ST_LOAD_HOLD) || (r_state == ST_JALR_WAIT);
  assign bus.insert_bubble = (r_state != ST_RUN);
  assign bus.flush_front   = (r_state == ST_FLUSH);

  sat_counter #(.WIDTH(PERF_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.insert_bubble),
    .clear (1'b0),
    .count (bus.stall_count)
  );

  sat_counter #(.WIDTH(PERF_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.flush_front),
    .clear (1'b0),
    .count (bus.flush_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_controller.sv
`default_nettype none
// ============================================================
// Module : tb_fetch_redirect_controller
// Directed stimulus with a cycle-tagged expectation queue and monitor.
// Rev    : 1.0
// ============================================================
module tb_fetch_redirect_controller;
  import fetch_redirect_controller_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  fetch_redirect_if #(.PERF_WIDTH(4)) bus ();

  fetch_redirect_controller #(.RESET_PC(32'h0000_0000), .PERF_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [1:0]  st;
    bit          chk;
    logic [3:0]  sc;
    logic [3:0]  fc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  bit   ok;
  logic e_stall, e_bub, e_fl;

  // Monitor: each expectation belongs to one cycle and is compared mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e   = q.pop_front();
      e_stall = (mon_e.st == ST_LOAD_HOLD) || (mon_e.st == ST_JALR_WAIT);
      e_bub   = (mon_e.st != ST_RUN);
      e_fl    = (mon_e.st == ST_FLUSH);
      checks++;
      ok = (mon_e.cyc == cyc) && (bus.pc === mon_e.pc) && (bus.state === mon_e.st) &&
           (bus.fetch_stall === e_stall) && (bus.insert_bubble === e_bub) &&
           (bus.flush_front === e_fl) &&
           (!mon_e.chk || ((bus.stall_count === mon_e.sc) && (bus.flush_count === mon_e.fc)));
      if (!ok) begin
        errors++;
        $display("FAIL cyc%0d step: got pc=%h st=%0d stall=%b bub=%b flush=%b sc=%0d fc=%0d; need cyc%0d pc=%h st=%0d stall=%b bub=%b flush=%b sc=%0d fc=%0d (cnt checked=%0d)",
                 cyc, bus.pc, bus.state, bus.fetch_stall, bus.insert_bubble, bus.flush_front,
                 bus.stall_count, bus.flush_count, mon_e.cyc, mon_e.pc, mon_e.st,
                 e_stall, e_bub, e_fl, mon_e.sc, mon_e.fc, mon_e.chk);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.fetch_rs1     = 5'd0;
    bus.fetch_rs2     = 5'd0;
    bus.fetch_is_jalr = 1'b0;
    bus.dec_valid     = 1'b0;
    bus.dec_is_load   = 1'b0;
    bus.dec_rd        = 5'd0;
    bus.jalr_resolve  = 1'b0;
    bus.jalr_target   = 32'h0;
    bus.mispredict    = 1'b0;
    bus.correct_pc    = 32'h0;
  endtask

  task automatic load_use(input logic [4:0] rd);
    bus.dec_valid   = 1'b1;
    bus.dec_is_load = 1'b1;
    bus.dec_rd      = rd;
    bus.fetch_rs2   = rd;
  endtask

  // Queue the expected outputs after the coming edge, then take that edge.
  task automatic step(input logic [31:0] pc, input logic [1:0] st, input bit chk,
                      input logic [3:0] sc, input logic [3:0] fc);
    exp_t e;
    e.cyc = cyc + 1;
    e.pc  = pc;
    e.st  = st;
    e.chk = chk;
    e.sc  = sc;
    e.fc  = fc;
    q.push_back(e);
    tick();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    bus.predict_pc = 32'h0;
    step(32'h0, ST_RUN, 1, 4'd0, 4'd0);
    step(32'h0, ST_RUN, 1, 4'd0, 4'd0);
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.predict_pc = 32'(i * 4);
      step(32'(i * 4), ST_RUN, 0, 4'd0, 4'd0);
    end

    // load-use at pc 0x10, held through LOAD_HOLD to show no double stall
    load_use(5'd5);
    bus.predict_pc = 32'h14;
    step(32'h10, ST_LOAD_HOLD, 0, 4'd0, 4'd0);
    step(32'h10, ST_RUN, 1, 4'd1, 4'd0);
    idle();
    step(32'h14, ST_RUN, 1, 4'd1, 4'd0);
    load_use(5'd0);
    bus.predict_pc = 32'h18;
    step(32'h18, ST_RUN, 1, 4'd1, 4'd0);
    idle();
    bus.predict_pc = 32'h1C;
    step(32'h1C, ST_RUN, 0, 4'd0, 4'd0);
    bus.predict_pc = 32'h20;
    step(32'h20, ST_RUN, 0, 4'd0, 4'd0);

    // JALR at 0x20, resolved three cycles later with a misaligned target
    bus.fetch_is_jalr = 1'b1;
    bus.predict_pc    = 32'h24;
    step(32'h20, ST_JALR_WAIT, 0, 4'd0, 4'd0);
    idle();
    step(32'h20, ST_JALR_WAIT, 0, 4'd0, 4'd0);
    step(32'h20, ST_JALR_WAIT, 0, 4'd0, 4'd0);
    bus.jalr_resolve = 1'b1;
    bus.jalr_target  = 32'h102;
    step(32'h100, ST_RUN, 1, 4'd4, 4'd0);
    bus.jalr_target = 32'h200;
    bus.predict_pc  = 32'h104;
    step(32'h104, ST_RUN, 0, 4'd0, 4'd0);

    // load-use outranks JALR; the held JALR then waits from RUN
    idle();
    bus.fetch_is_jalr = 1'b1;
    load_use(5'd3);
    bus.fetch_rs2  = 5'd0;
    bus.fetch_rs1  = 5'd3;
    bus.predict_pc = 32'h108;
    step(32'h104, ST_LOAD_HOLD, 0, 4'd0, 4'd0);
    idle();
    bus.fetch_is_jalr = 1'b1;
    step(32'h104, ST_RUN, 0, 4'd0, 4'd0);
    step(32'h104, ST_JALR_WAIT, 1, 4'd5, 4'd0);

    // mispredict wins over a same-cycle jalr_resolve
    idle();
    bus.mispredict   = 1'b1;
    bus.correct_pc   = 32'h40;
    bus.jalr_resolve = 1'b1;
    bus.jalr_target  = 32'h80;
    step(32'h40, ST_FLUSH, 1, 4'd6, 4'd0);
    bus.mispredict = 1'b0;
    bus.predict_pc = 32'h44;
    step(32'h44, ST_RUN, 1, 4'd7, 4'd1);

    // mispredict wins over load-use; correct_pc low bits dropped
    idle();
    load_use(5'd7);
    bus.mispredict = 1'b1;
    bus.correct_pc = 32'h53;
    step(32'h50, ST_FLUSH, 0, 4'd0, 4'd0);
    idle();
    bus.predict_pc = 32'h54;
    step(32'h54, ST_RUN, 1, 4'd8, 4'd2);

    // stall counter saturation
    for (int i = 0; i < 20; i++) begin
      load_use(5'd9);
      step(32'h54, ST_LOAD_HOLD, 0, 4'd0, 4'd0);
      idle();
      step(32'h54, ST_RUN, 0, 4'd0, 4'd0);
    end
    bus.predict_pc = 32'h58;
    step(32'h58, ST_RUN, 1, 4'd15, 4'd2);

    // reset mid-JALR_WAIT, later jalr_resolve ignored
    bus.fetch_is_jalr = 1'b1;
    bus.predict_pc    = 32'h5C;
    step(32'h58, ST_JALR_WAIT, 0, 4'd0, 4'd0);
    idle();
    step(32'h58, ST_JALR_WAIT, 0, 4'd0, 4'd0);
    reset = 1'b0;
    step(32'h0, ST_RUN, 1, 4'd0, 4'd0);
    reset = 1'b1;
    bus.jalr_resolve = 1'b1;
    bus.jalr_target  = 32'h300;
    bus.predict_pc   = 32'h4;
    step(32'h4, ST_RUN, 1, 4'd0, 4'd0);

    // reset mid-FLUSH
    idle();
    bus.mispredict = 1'b1;
    bus.correct_pc = 32'h70;
    step(32'h70, ST_FLUSH, 0, 4'd0, 4'd0);
    idle();
    reset = 1'b0;
    step(32'h0, ST_RUN, 1, 4'd0, 4'd0);
    reset = 1'b1;
    bus.predict_pc = 32'h8;
    step(32'h8, ST_RUN, 1, 4'd0, 4'd0);

    repeat (2) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, need 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
